// File: rtl/morse_tx_controller.sv
// Morse keying sequencer: digit -> encoder handshake -> timed tx marks/spaces.
// Ports: clk, reset, start/digit request; enc_digit/enc_ready/enc_code to the
// encoder; tx keying line; busy, done, err status; elem_idx element index.
module morse_tx_controller #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] digit,
    output logic [3:0] enc_digit,
    output logic       enc_ready,
    input  logic [4:0] enc_code,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] elem_idx
);

    localparam int CW = $clog2(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] ONE_U   = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] THREE_U = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        SPACE,
        GAP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_ld;
    logic [4:0]    pat;
    logic          accept;
    logic          reject;
    logic          expire;
    logic          mark_bit;

    assign expire = (cnt == '0);
    assign accept = (state == IDLE) && start && (digit <= 4'd9);
    assign reject = (state == IDLE) && start && (digit > 4'd9);

    // Bit of the mark about to start: fresh encoder output when leaving
    // LOAD, otherwise the next pattern bit that SPACE is shifting up.
    assign mark_bit = (state == LOAD) ? enc_code[4] : pat[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    state_nx = MARK;
            MARK:    if (expire) state_nx = (elem_idx == 3'd4) ? GAP : SPACE;
            SPACE:   if (expire) state_nx = MARK;
            GAP:     if (expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_ld = '0;
        unique case (state_nx)
            MARK:    cnt_ld = mark_bit ? ONE_U : THREE_U;
            SPACE:   cnt_ld = ONE_U;
            GAP:     cnt_ld = THREE_U;
            default: cnt_ld = '0;
        endcase
    end

    always_comb begin
        tx        = (state == MARK);
        busy      = (state != IDLE);
        enc_ready = (state == LOAD);
    end

    // Datapath: unit counter, pattern shifter, element index, pulses.
    // The pattern rotates rather than shifts; only the top bits are read.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            pat       <= '0;
            elem_idx  <= '0;
            enc_digit <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (state_nx != state) begin
                cnt <= cnt_ld;
            end else if (!expire) begin
                cnt <= cnt - CW'(1);
            end

            if (state == LOAD) begin
                pat <= enc_code;
            end else if (state == SPACE && expire) begin
                pat <= {pat[3:0], pat[4]};
            end

            if (state == LOAD) begin
                elem_idx <= '0;
            end else if (state == SPACE && expire) begin
                elem_idx <= elem_idx + 3'd1;
            end else if (state == GAP && expire) begin
                elem_idx <= '0;
            end

            if (accept) begin
                enc_digit <= digit;
            end

            done <= (state == GAP) && expire;
            err  <= reject;
        end
    end

endmodule
